vaddr_offset_tracker: RTL and testbench

- Parametrised successor to the two-slot vaddr offset valid tracker in the memops scheduler.
- Captures up to DEPTH distinct virtual-address offsets presented during one NDP operation.
- Stores the offsets internally and drives per-entry valid bits, a fill count and full/duplicate/overflow status to the scheduler.
- All state clears at the end of each NDP operation (ndp_done) or on reset.

---
 rtl/vaddr_offset_tracker.sv | 93 +++++++++
 tb/tb_vaddr_offset_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vaddr_offset_tracker.sv
// Captures up to DEPTH distinct virtual-address offsets per NDP operation,
// reporting per-entry valids, fill count and full/duplicate/overflow status.
module vaddr_offset_tracker #(
    parameter int  OFFSET_W = 64,
    parameter int  DEPTH    = 4,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      ndp_done,
    input  logic                      offset_valid,
    input  logic [OFFSET_W-1:0]       offset,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [DEPTH*OFFSET_W-1:0] entry_offset,
    output logic [CNT_W-1:0]          entry_count,
    output logic                      full,
    output logic                      dup_pulse,
    output logic                      overflow
);

    logic [OFFSET_W-1:0] entry_q [DEPTH];
    logic [OFFSET_W-1:0] entry_d [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    match;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                dup_q, dup_d;
    logic                ovf_q, ovf_d;
    logic                hit;
    logic                full_w;

    // Only valid entries can match, so a cleared (zero) slot never aliases offset 0.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (entry_q[i] == offset);
        end
    end

    assign hit    = |match;
    assign full_w = (count_q == CNT_W'(DEPTH));

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        count_d = count_q;
        dup_d   = 1'b0;
        ovf_d   = ovf_q;
        if (offset_valid) begin
            if (hit) begin
                dup_d = 1'b1;
            end else if (full_w) begin
                ovf_d = 1'b1;
            end else begin
                // Entries fill in order, so the count is also the next free slot.
                for (int i = 0; i < DEPTH; i++) begin
                    if (count_q == CNT_W'(i)) begin
                        entry_d[i] = offset;
                        valid_d[i] = 1'b1;
                    end
                end
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn || ndp_done) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            count_q <= count_d;
            dup_q   <= dup_d;
            ovf_q   <= ovf_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign entry_offset[g*OFFSET_W +: OFFSET_W] = entry_q[g];
    end

    assign entry_valid = valid_q;
    assign entry_count = count_q;
    assign full        = full_w;
    assign dup_pulse   = dup_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_vaddr_offset_tracker.sv
// Bench for vaddr_offset_tracker: directed and random offsets on a DEPTH=4
// instance against a queue model, plus a directed DEPTH=2 compatibility run.
module tb_vaddr_offset_tracker;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         ndp_done;
    logic         offset_valid;
    logic [63:0]  offset;
    logic [3:0]   ev4;
    logic [255:0] eo4;
    logic [2:0]   ec4;
    logic         full4, dup4, ovf4;

    logic         offset_valid2;
    logic [63:0]  offset2;
    logic [1:0]   ev2;
    logic [127:0] eo2;
    logic [1:0]   ec2;
    logic         full2, dup2, ovf2;

    int tests = 0;
    int fails = 0;

    logic [63:0] mq[$];
    bit          mdup;
    bit          movf;

    always #5 clk = ~clk;

    vaddr_offset_tracker #(.OFFSET_W(64), .DEPTH(4)) dut4 (
        .clk(clk), .aresetn(aresetn), .ndp_done(ndp_done),
        .offset_valid(offset_valid), .offset(offset),
        .entry_valid(ev4), .entry_offset(eo4), .entry_count(ec4),
        .full(full4), .dup_pulse(dup4), .overflow(ovf4)
    );

    vaddr_offset_tracker #(.OFFSET_W(64), .DEPTH(2)) dut2 (
        .clk(clk), .aresetn(aresetn), .ndp_done(ndp_done),
        .offset_valid(offset_valid2), .offset(offset2),
        .entry_valid(ev2), .entry_offset(eo2), .entry_count(ec2),
        .full(full2), .dup_pulse(dup2), .overflow(ovf2)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_model(input logic [63:0] v);
        foreach (mq[i]) if (mq[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Reference behaviour of one clock edge for the DEPTH=4 tracker.
    task automatic model_edge(input logic rn, input logic dn, input logic v, input logic [63:0] off);
        if (!rn || dn) begin
            mq.delete();
            mdup = 1'b0;
            movf = 1'b0;
        end else begin
            mdup = 1'b0;
            if (v) begin
                if (in_model(off))      mdup = 1'b1;
                else if (mq.size() == 4) movf = 1'b1;
                else                     mq.push_back(off);
            end
        end
    endtask

    task automatic check4(input string tag);
        logic [255:0] eo;
        logic [3:0]   ev;
        eo = '0;
        ev = '0;
        foreach (mq[i]) begin
            eo[i*64 +: 64] = mq[i];
            ev[i] = 1'b1;
        end
        chk({tag, ".valid"}, 256'(ev4), 256'(ev));
        chk({tag, ".count"}, 256'(ec4), 256'(mq.size()));
        chk({tag, ".full"},  256'(full4), 256'(mq.size() == 4));
        chk({tag, ".dup"},   256'(dup4), 256'(mdup));
        chk({tag, ".ovf"},   256'(ovf4), 256'(movf));
        chk({tag, ".data"},  eo4, eo);
    endtask

    task automatic step(input string tag, input logic rn, input logic dn,
                        input logic v, input logic [63:0] off);
        aresetn      = rn;
        ndp_done     = dn;
        offset_valid = v;
        offset       = off;
        @(posedge clk);
        model_edge(rn, dn, v, off);
        #1;
        check4(tag);
    endtask

    task automatic step2(input logic v, input logic [63:0] off);
        offset_valid2 = v;
        offset2       = off;
        @(posedge clk);
        #1;
        offset_valid2 = 1'b0;
    endtask

    initial begin
        logic [63:0] a, b, c;
        aresetn = 1'b0; ndp_done = 1'b0; offset_valid = 1'b0; offset = '0;
        offset_valid2 = 1'b0; offset2 = '0;
        mq.delete(); mdup = 1'b0; movf = 1'b0;

        step("rst0", 1'b0, 1'b0, 1'b0, 64'h0);
        step("rst1", 1'b0, 1'b0, 1'b1, 64'h9000);
        step("idle", 1'b1, 1'b0, 1'b0, 64'h0);
        chk("rst.dup2", 256'(dup2), 256'(0));
        chk("rst.cnt2", 256'(ec2), 256'(0));

        step("fill1", 1'b1, 1'b0, 1'b1, 64'h1000);
        step("fill2", 1'b1, 1'b0, 1'b1, 64'h2000);
        step("fill3", 1'b1, 1'b0, 1'b1, 64'h3000);
        step("fill4", 1'b1, 1'b0, 1'b1, 64'h4000);
        chk("fill.full", 256'(full4), 256'(1));
        step("ovf", 1'b1, 1'b0, 1'b1, 64'h5000);
        for (int i = 0; i < 10; i++) step("ovf.hold", 1'b1, 1'b0, 1'b0, 64'h5000);
        chk("ovf.sticky", 256'(ovf4), 256'(1));
        step("dupfull", 1'b1, 1'b0, 1'b1, 64'h2000);
        step("dupfull.end", 1'b1, 1'b0, 1'b0, 64'h0);

        step("clr", 1'b1, 1'b1, 1'b1, 64'h7000);
        step("cap7", 1'b1, 1'b0, 1'b1, 64'h7000);
        chk("cap7.e0", eo4[63:0], 256'h7000);
        step("dup7", 1'b1, 1'b0, 1'b1, 64'h7000);
        step("dup7.end", 1'b1, 1'b0, 1'b0, 64'h7000);
        step("zero", 1'b1, 1'b0, 1'b1, 64'h0);
        step("midrst", 1'b0, 1'b0, 1'b1, 64'h8000);
        step("after", 1'b1, 1'b0, 1'b1, 64'h8000);

        // DEPTH=2 compatibility run: A, A, B, C.
        a = 64'hA0A0_0000_0000_1111;
        b = 64'hB0B0_0000_0000_2222;
        c = 64'hC0C0_0000_0000_3333;
        step2(1'b1, a);
        chk("d2.A.valid", 256'(ev2), 256'(2'b01));
        chk("d2.A.cnt",   256'(ec2), 256'(1));
        step2(1'b1, a);
        chk("d2.AA.valid", 256'(ev2), 256'(2'b01));
        chk("d2.AA.dup",   256'(dup2), 256'(1));
        step2(1'b1, b);
        chk("d2.B.valid", 256'(ev2), 256'(2'b11));
        chk("d2.B.full",  256'(full2), 256'(1));
        chk("d2.B.dup",   256'(dup2), 256'(0));
        step2(1'b1, c);
        chk("d2.C.valid", 256'(ev2), 256'(2'b11));
        chk("d2.C.ovf",   256'(ovf2), 256'(1));
        chk("d2.C.cnt",   256'(ec2), 256'(2));
        chk("d2.C.data",  256'(eo2), 256'({b, a}));

        for (int n = 0; n < 400; n++) begin
            logic rn, dn, v;
            logic [63:0] off;
            rn  = ($urandom_range(0, 49) != 0);
            dn  = ($urandom_range(0, 29) == 0);
            v   = ($urandom_range(0, 9) < 7);
            off = 64'($urandom_range(0, 7)) << 12;
            if ($urandom_range(0, 7) == 0) off = {$urandom, $urandom};
            step("rand", rn, dn, v, off);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
